job_status_writer: RTL and testbench
====================================

JOB_STATUS_WRITER -- requirements
Module: job_status_writer

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 1, AXI ID width.
REQ-002 SHALL have parameter AWUSER_WIDTH, default 8, AXI AWUSER width.
REQ-003 SHALL have parameter DATA_WIDTH, default 512, AXI data width, fixed to 512.
REQ-004 SHALL have parameter ADDR_WIDTH, default 64, AXI address width.
REQ-005 SHALL have parameter QUEUE_DEPTH, default 4, completion-request queue entries, power of two.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst_n, input, 1, reset; one clock; reset is synchronous and active-low.
REQ-008 SHALL have req_valid in 1, req_ready out 1, a completion-request handshake.
REQ-009 SHALL have req_addr in 64, req_job_id in 32, req_status in 32, the request payload.
REQ-010 SHALL have full AXI4 write-master ports m_axi_aw*, m_axi_w*, m_axi_b*, with the same names and widths as the other AXI masters in this codebase.
REQ-011 SHALL have busy out 1, done_count out 32, err_flag out 1 and err_count out 16.

Function
REQ-012 SHALL accept a request when req_valid & req_ready, push {addr, job_id, status} into a FIFO and assert req_ready = !full, computed from current occupancy only.
REQ-013 SHALL, when push and pop occur in the same cycle, leave occupancy unchanged; push when full is impossible because req_ready=0.
REQ-014 SHALL implement FSM IDLE -> SEND -> RESP -> IDLE.
REQ-015 IDLE: SHALL pop the FIFO head when not empty, latch it and a sequence number, and go to SEND on the next edge.
REQ-016 SEND: SHALL assert m_axi_awvalid and m_axi_wvalid together in the first SEND cycle.
REQ-017 SHALL drop each valid the cycle after its own handshake, independently, with aw_done and w_done flags.
REQ-018 SHALL go to RESP once both flags are set, including when both handshakes land in the same cycle or W precedes AW.
REQ-019 RESP: SHALL hold m_axi_bready=1 and return to IDLE on m_axi_bvalid; bready=0 in all other states.
REQ-020 SHALL drive AW fields as awaddr = latched addr, awlen=0, awsize=6, awburst=1 (INCR), awcache=3, awid/awuser/awprot/awqos/awregion/awlock=0.
REQ-021 SHALL drive W fields as wlast=1 with wvalid, wstrb all ones, and wid=0.
REQ-022 SHALL build wdata from [31:0]=job_id, [63:32]=status, [95:64]=seq, [127:96]=32'h600D_F00D, with all other bits 0.
REQ-023 SHALL start seq at 0, increment it by 1 per popped request and wrap at 2^32.
REQ-024 SHALL increment done_count by 1 on every B handshake and wrap at 2^32.
REQ-025 SHALL, when bresp!=0 on a B handshake, set err_flag (sticky until reset) and increment err_count, saturating at 16'hFFFF.
REQ-026 SHALL drive busy=1 when the state is not IDLE or the FIFO is non-empty.
REQ-027 SHALL keep at most one write outstanding; latency from accepted request in an empty FIFO to awvalid SHALL be 2 cycles.
REQ-028 SHALL keep AW/W payloads stable while valid and not yet accepted.

Reset
REQ-029 SHALL, with rst_n=0 at a clk edge, return the FSM to IDLE, empty the FIFO and clear seq, done_count, err_count, err_flag, awvalid, wvalid, bready and the flags.
REQ-030 SHALL, on reset mid-transaction, abandon in-flight writes without waiting for B; req_ready=1 the cycle after reset releases.

Structure
REQ-031 SHALL place FSM state encodings, the magic constant 32'h600D_F00D and the record field offsets in a shared package job_pkg.
REQ-032 SHALL implement the queue as sub-module job_req_fifo (synchronous, parameterised depth/width, full/empty flags).

Verification
REQ-033 Bench SHALL cover: one request (addr 0x1000, id 7, status 0) with awready/wready=1 -> awaddr 0x1000, wdata[127:0]=0x600DF00D_00000000_00000000_00000007, done_count=1.
REQ-034 Bench SHALL cover: wready held 0 for 5 cycles after AW accepts -> wvalid stays 1 with stable data and FSM enters RESP only after W accepts.
REQ-035 Bench SHALL cover: 5 back-to-back requests with bvalid stalled -> req_ready=0 after 4 accepted plus 1 popped (occupancy 4) and all 5 written in order with seq 0..4.
REQ-036 Bench SHALL cover: bresp=2 on the 2nd write -> err_flag=1 and err_count=1, with done_count still incrementing to 2.
REQ-037 Bench SHALL cover: rst_n low for 1 cycle during SEND -> awvalid=wvalid=0, busy=0, counters 0 and a new request is accepted next cycle.

Source files
------------

// File: rtl/job_pkg.sv
// job_pkg: shared FSM encoding, record layout and payload format for the job status writer.
package job_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RESP = 2'd2
  } state_t;
  localparam logic [31:0] JOB_MAGIC = 32'h600D_F00D;
  localparam int REC_JOB_LSB    = 0;
  localparam int REC_STATUS_LSB = 32;
  localparam int REC_ADDR_LSB   = 64;
  localparam int REC_W          = 128;
  localparam int WD_JOB_LSB     = 0;
  localparam int WD_STATUS_LSB  = 32;
  localparam int WD_SEQ_LSB     = 64;
  localparam int WD_MAGIC_LSB   = 96;
  function automatic logic [127:0] pack_wdata(input logic [31:0] job_id, status, seq);
    logic [127:0] w;
    w = '0;
    w[WD_JOB_LSB +: 32]    = job_id;
    w[WD_STATUS_LSB +: 32] = status;
    w[WD_SEQ_LSB +: 32]    = seq;
    w[WD_MAGIC_LSB +: 32]  = JOB_MAGIC;
    return w;
  endfunction
endpackage

// File: rtl/job_req_fifo.sv
// job_req_fifo: synchronous show-ahead FIFO holding pending completion requests.
module job_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  assign full    = cnt == (PW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign rd_data = mem[rp];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wr_data;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

// File: rtl/job_status_writer.sv
// job_status_writer: queues job completion records and writes each as a single-beat AXI4 status write.
module job_status_writer #(
  parameter int ID_WIDTH     = 1,
  parameter int AWUSER_WIDTH = 8,
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 64,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [63:0]               req_addr,
  input  logic [31:0]               req_job_id,
  input  logic [31:0]               req_status,
  output logic [ID_WIDTH-1:0]       m_axi_awid,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awlock,
  output logic [3:0]                m_axi_awcache,
  output logic [2:0]                m_axi_awprot,
  output logic [3:0]                m_axi_awqos,
  output logic [3:0]                m_axi_awregion,
  output logic [AWUSER_WIDTH-1:0]   m_axi_awuser,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [ID_WIDTH-1:0]       m_axi_wid,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic                      busy,
  output logic [31:0]               done_count,
  output logic                      err_flag,
  output logic [15:0]               err_count
);
  import job_pkg::*;
  state_t state;
  logic [REC_W-1:0] rec_in, rec_out;
  logic full, empty, push, pop, aw_hs, w_hs, aw_done, w_done, unused_bid;
  logic [63:0] cur_addr;
  logic [31:0] cur_job, cur_status, cur_seq, seq;
  always_comb begin
    rec_in = '0;
    rec_in[REC_ADDR_LSB +: 64]   = req_addr;
    rec_in[REC_JOB_LSB +: 32]    = req_job_id;
    rec_in[REC_STATUS_LSB +: 32] = req_status;
  end
  assign req_ready  = !full;
  assign push       = req_valid && req_ready;
  assign pop        = state == ST_IDLE && !empty;
  assign aw_hs      = m_axi_awvalid && m_axi_awready;
  assign w_hs       = m_axi_wvalid && m_axi_wready;
  assign busy       = state != ST_IDLE || !empty;
  assign unused_bid = ^m_axi_bid;
  job_req_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(REC_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .wr_data(rec_in), .rd_data(rec_out), .full(full), .empty(empty)
  );
  assign m_axi_awid     = '0;
  assign m_axi_awaddr   = ADDR_WIDTH'(cur_addr);
  assign m_axi_awlen    = 8'd0;
  assign m_axi_awsize   = 3'd6;
  assign m_axi_awburst  = 2'd1;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = 4'd3;
  assign m_axi_awprot   = '0;
  assign m_axi_awqos    = '0;
  assign m_axi_awregion = '0;
  assign m_axi_awuser   = '0;
  assign m_axi_wid      = '0;
  assign m_axi_wdata    = DATA_WIDTH'(pack_wdata(cur_job, cur_status, cur_seq));
  assign m_axi_wstrb    = '1;
  assign m_axi_wlast    = m_axi_wvalid;
  // AW and W retire independently; RESP is entered on the edge that completes the later of the two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      seq           <= '0;
      done_count    <= '0;
      err_count     <= '0;
      err_flag      <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      cur_addr      <= '0;
      cur_job       <= '0;
      cur_status    <= '0;
      cur_seq       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (pop) begin
          cur_addr      <= rec_out[REC_ADDR_LSB +: 64];
          cur_job       <= rec_out[REC_JOB_LSB +: 32];
          cur_status    <= rec_out[REC_STATUS_LSB +: 32];
          cur_seq       <= seq;
          seq           <= seq + 32'd1;
          m_axi_awvalid <= 1'b1;
          m_axi_wvalid  <= 1'b1;
          aw_done       <= 1'b0;
          w_done        <= 1'b0;
          state         <= ST_SEND;
        end
        ST_SEND: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            m_axi_bready <= 1'b1;
            state        <= ST_RESP;
          end
        end
        ST_RESP: if (m_axi_bvalid && m_axi_bready) begin
          m_axi_bready <= 1'b0;
          done_count   <= done_count + 32'd1;
          state        <= ST_IDLE;
          if (m_axi_bresp != 2'b00) begin
            err_flag  <= 1'b1;
            err_count <= err_count == 16'hFFFF ? err_count : err_count + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_job_status_writer.sv
// tb_job_status_writer: vector table, directed corner sequences and random traffic against a transaction-level model.
module tb_job_status_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req_valid, req_ready;
  logic [63:0] req_addr;
  logic [31:0] req_job_id, req_status;
  logic [0:0] m_axi_awid, m_axi_wid, m_axi_bid;
  logic [63:0] m_axi_awaddr;
  logic [7:0] m_axi_awlen, m_axi_awuser;
  logic [2:0] m_axi_awsize, m_axi_awprot;
  logic [1:0] m_axi_awburst, m_axi_bresp;
  logic [3:0] m_axi_awcache, m_axi_awqos, m_axi_awregion;
  logic m_axi_awlock, m_axi_awvalid, m_axi_awready;
  logic [511:0] m_axi_wdata;
  logic [63:0] m_axi_wstrb;
  logic m_axi_wlast, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
  logic busy, err_flag;
  logic [31:0] done_count;
  logic [15:0] err_count;

  job_status_writer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_job_id(req_job_id), .req_status(req_status),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awregion(m_axi_awregion), .m_axi_awuser(m_axi_awuser), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wid(m_axi_wid), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .busy(busy),
    .done_count(done_count), .err_flag(err_flag), .err_count(err_count)
  );

  int checks = 0;
  int errors = 0;
  int aw_lat = 0, w_lat = 0, b_lat = 0;
  logic b_stall = 1'b0, rnd_mode = 1'b0;
  logic [1:0] b_resp_k = 2'd0;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] id;
    logic [31:0] st;
    logic [31:0] seq;
  } exp_t;
  exp_t exp_q[$];
  int aw_n, w_n, b_n;
  logic [31:0] seq_m, done_m;
  logic [15:0] errc_m;
  logic flag_m, prev_aw, prev_w;
  logic [63:0] last_awaddr, prev_awaddr;
  logic [511:0] last_wdata, prev_wdata;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] model_w(input exp_t e);
    logic [511:0] w;
    w = '0;
    w[31:0]   = e.id;
    w[63:32]  = e.st;
    w[95:64]  = e.seq;
    w[127:96] = 32'h600DF00D;
    return w;
  endfunction

  task automatic push_req(input logic [63:0] a, input logic [31:0] id, input logic [31:0] st, output int waits);
    bit ok;
    ok = 0;
    waits = 0;
    req_addr = a;
    req_job_id = id;
    req_status = st;
    req_valid = 1'b1;
    while (!ok && waits < 500) begin
      @(negedge clk);
      if (req_ready) ok = 1;
      else begin
        waits++;
        step();
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: req_ready stayed 0 for %0d cycles, required 1", waits);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (done_count == 32'(n)) ok = 1;
      else step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done_count %0d required %0d", done_count, n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // AXI slave responder: fixed per-channel latencies, or coin-flip readiness in random mode.
  initial begin
    int awc, wc, bc;
    awc = 0; wc = 0; bc = 0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_bresp = 2'd0; m_axi_bid = '0;
    forever begin
      step();
      if (rnd_mode) begin
        m_axi_awready = 1'($urandom);
        m_axi_wready  = 1'($urandom);
        m_axi_bvalid  = m_axi_bready && 1'($urandom);
        m_axi_bresp   = ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd0;
      end else begin
        if (!m_axi_awvalid) begin awc = 0; m_axi_awready = 1'b0; end
        else if (awc >= aw_lat) m_axi_awready = 1'b1;
        else begin m_axi_awready = 1'b0; awc++; end
        if (!m_axi_wvalid) begin wc = 0; m_axi_wready = 1'b0; end
        else if (wc >= w_lat) m_axi_wready = 1'b1;
        else begin m_axi_wready = 1'b0; wc++; end
        if (!m_axi_bready || b_stall) begin bc = 0; m_axi_bvalid = 1'b0; end
        else if (bc >= b_lat) begin m_axi_bvalid = 1'b1; m_axi_bresp = b_resp_k; end
        else begin m_axi_bvalid = 1'b0; bc++; end
      end
    end
  end

  // Transaction-level model: every accepted request must be written once, in order, with seq = its index since reset.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        aw_n = 0; w_n = 0; b_n = 0;
        seq_m = 0; done_m = 0; errc_m = 0; flag_m = 0;
        prev_aw = 0; prev_w = 0;
      end else begin
        chk("done_count", 512'(done_count), 512'(done_m));
        chk("err_count", 512'(err_count), 512'(errc_m));
        chk("err_flag", 512'(err_flag), 512'(flag_m));
        chk("busy", 512'(busy), 512'(exp_q.size() != b_n));
        if (prev_aw && m_axi_awvalid) chk("aw_stable", 512'(m_axi_awaddr), 512'(prev_awaddr));
        if (prev_w && m_axi_wvalid) chk("w_stable", m_axi_wdata, prev_wdata);
        prev_aw = m_axi_awvalid && !m_axi_awready;
        prev_w = m_axi_wvalid && !m_axi_wready;
        prev_awaddr = m_axi_awaddr;
        prev_wdata = m_axi_wdata;
        if (m_axi_awvalid && m_axi_awready) begin
          if (aw_n >= exp_q.size()) begin
            checks++; errors++;
            $display("FAIL aw_spurious: AW #%0d with only %0d requests accepted", aw_n, exp_q.size());
          end else begin
            chk("awaddr", 512'(m_axi_awaddr), 512'(exp_q[aw_n].addr));
            chk("aw_outstanding", 512'(b_n), 512'(aw_n));
            chk("aw_fields", 512'({m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                                   m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion, m_axi_awuser}),
                512'({1'b0, 8'd0, 3'd6, 2'd1, 1'b0, 4'd3, 3'd0, 4'd0, 4'd0, 8'd0}));
          end
          last_awaddr = m_axi_awaddr;
          aw_n++;
        end
        if (m_axi_wvalid && m_axi_wready) begin
          if (w_n >= exp_q.size()) begin
            checks++; errors++;
            $display("FAIL w_spurious: W #%0d with only %0d requests accepted", w_n, exp_q.size());
          end else begin
            chk("wdata", m_axi_wdata, model_w(exp_q[w_n]));
            chk("w_outstanding", 512'(b_n), 512'(w_n));
            chk("w_fields", 512'({m_axi_wid, m_axi_wlast, m_axi_wstrb}), 512'({1'b0, 1'b1, {64{1'b1}}}));
          end
          last_wdata = m_axi_wdata;
          w_n++;
        end
        if (m_axi_bvalid && m_axi_bready) begin
          chk("b_after_aw_w", 512'(b_n < aw_n && b_n < w_n), 512'(1));
          done_m++;
          if (m_axi_bresp != 2'd0) begin
            flag_m = 1'b1;
            if (errc_m != 16'hFFFF) errc_m++;
          end
          b_n++;
        end
        if (req_valid && req_ready) begin
          exp_q.push_back('{req_addr, req_job_id, req_status, seq_m});
          seq_m++;
        end
      end
    end
  end

  typedef struct {
    logic [63:0]  addr;
    logic [31:0]  id;
    logic [31:0]  st;
    logic [1:0]   resp;
    int           aw_lat;
    int           w_lat;
    int           b_lat;
    logic [127:0] exp_w;
    int           exp_done;
    int           exp_errc;
    logic         exp_flag;
  } vec_t;
  vec_t vt[4];

  initial begin
    int waits, tot, n;
    bit hs;
    vt[0] = '{64'h1000, 32'd7, 32'd0, 2'd0, 0, 0, 0,
              128'h600DF00D_00000000_00000000_00000007, 1, 0, 1'b0};
    vt[1] = '{64'h2040, 32'h11, 32'hAB, 2'd2, 1, 3, 2,
              128'h600DF00D_00000001_000000AB_00000011, 2, 1, 1'b1};
    vt[2] = '{64'h3000, 32'hDEADBEEF, 32'h12345678, 2'd0, 4, 0, 0,
              128'h600DF00D_00000002_12345678_DEADBEEF, 3, 1, 1'b1};
    vt[3] = '{64'hFFFF_FFFF_FFFF_FFC0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd3, 2, 2, 5,
              128'h600DF00D_00000003_FFFFFFFF_FFFFFFFF, 4, 2, 1'b1};
    req_valid = 1'b0; req_addr = '0; req_job_id = '0; req_status = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_flags", 512'({req_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, err_flag}), 512'(6'b100000));
    chk("reset_counts", 512'({done_count, err_count}), 512'(0));
    step();
    for (int i = 0; i < 4; i++) begin
      aw_lat = vt[i].aw_lat; w_lat = vt[i].w_lat; b_lat = vt[i].b_lat; b_resp_k = vt[i].resp;
      push_req(vt[i].addr, vt[i].id, vt[i].st, waits);
      @(negedge clk);
      chk("lat_not_yet", 512'(m_axi_awvalid), 512'(0));
      step();
      @(negedge clk);
      chk("lat_aw_w_valid", 512'({m_axi_awvalid, m_axi_wvalid}), 512'(2'b11));
      step();
      wait_done(vt[i].exp_done);
      chk("row_err_count", 512'(err_count), 512'(vt[i].exp_errc));
      chk("row_err_flag", 512'(err_flag), 512'(vt[i].exp_flag));
      chk("row_awaddr", 512'(last_awaddr), 512'(vt[i].addr));
      chk("row_wdata", 512'(last_wdata[127:0]), 512'(vt[i].exp_w));
      chk("row_wdata_high", 512'(last_wdata[511:128]), 512'(0));
      chk("row_idle", 512'(busy), 512'(0));
      step();
    end
    tot = 4;
    // W stalled 5 cycles past the AW handshake
    aw_lat = 0; w_lat = 6; b_lat = 0; b_resp_k = 2'd0;
    push_req(64'h4000, 32'h44, 32'h4, waits);
    tot++;
    n = 0; hs = 0;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      if (m_axi_wvalid && m_axi_wready) hs = 1;
      else if (m_axi_wvalid) begin
        chk("w_stall_no_resp", 512'(m_axi_bready), 512'(0));
        chk("w_stall_aw", 512'(m_axi_awvalid), 512'(n == 0));
        n++;
      end
      step();
    end
    chk("w_stall_seen", 512'(hs), 512'(1));
    chk("w_stall_cycles", 512'(n), 512'(6));
    @(negedge clk);
    chk("resp_after_w", 512'(m_axi_bready), 512'(1));
    step();
    wait_done(tot);
    step();
    // five back-to-back requests behind a stalled B channel
    do_reset();
    tot = 0;
    b_stall = 1'b1; w_lat = 0;
    for (int k = 0; k < 5; k++) begin
      push_req(64'h5000 + 64'(k * 64), 32'(100 + k), 32'(k), waits);
      chk("b2b_accept", 512'(waits), 512'(0));
      tot++;
    end
    @(negedge clk);
    chk("full_ready", 512'(req_ready), 512'(0));
    chk("full_one_outstanding", 512'({busy, m_axi_bready, m_axi_awvalid}), 512'(3'b110));
    step();
    b_stall = 1'b0;
    wait_done(tot);
    chk("b2b_last_seq", 512'(last_wdata[95:64]), 512'(4));
    chk("b2b_last_addr", 512'(last_awaddr), 512'(64'h5100));
    step();
    // reset while stuck in SEND
    w_lat = 100;
    push_req(64'h7000, 32'h77, 32'h1, waits);
    @(negedge clk);
    step();
    @(negedge clk);
    chk("send_before_rst", 512'(m_axi_wvalid), 512'(1));
    step();
    do_reset();
    @(negedge clk);
    chk("rst_flags", 512'({req_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, err_flag}), 512'(6'b100000));
    chk("rst_counts", 512'({done_count, err_count}), 512'(0));
    step();
    w_lat = 0;
    push_req(64'h8000, 32'h88, 32'h2, waits);
    chk("post_rst_accept", 512'(waits), 512'(0));
    wait_done(1);
    chk("post_rst_seq", 512'(last_wdata[95:64]), 512'(0));
    chk("post_rst_addr", 512'(last_awaddr), 512'(64'h8000));
    step();
    tot = 1;
    rnd_mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) step();
      push_req({$urandom, $urandom}, $urandom, $urandom, waits);
      tot++;
    end
    wait_done(tot);
    step();
    rnd_mode = 1'b0;
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
